// File: rtl/blk_359621_if.sv
// rtl/blk_359621_if.sv - channel status / trigger / decode bus for the empty-status updater
interface blk_359621_if #(
  parameter int NC = 4,
  parameter int CW = 3,
  parameter int PW = 2
);
  logic [NC-1:0]    input_channel_empty_status;
  logic [NC*CW-1:0] input_channel_counts;
  logic             trigger_valid;
  logic [NC-1:0]    trigger_icd;
  logic [NC-1:0]    decode_dequeue;
  logic             pipeline_flush;
  logic [NC-1:0]    updated_input_channel_empty_status;
  logic [NC*PW-1:0] pending_dequeue_counts;
  logic             error;

  modport master (
    output input_channel_empty_status, input_channel_counts, trigger_valid,
           trigger_icd, decode_dequeue, pipeline_flush,
    input  updated_input_channel_empty_status, pending_dequeue_counts, error
  );

  modport slave (
    input  input_channel_empty_status, input_channel_counts, trigger_valid,
           trigger_icd, decode_dequeue, pipeline_flush,
    output updated_input_channel_empty_status, pending_dequeue_counts, error
  );
endinterface

// File: rtl/blk_359621.sv
// rtl/blk_359621.sv - per-channel in-flight dequeue counter masking input channels as empty
module blk_359621 #(
  parameter int NUM_INPUT_CHANNELS   = 4,
  parameter int CHANNEL_BUFFER_DEPTH = 4,
  parameter int MAX_IN_FLIGHT        = 3,
  parameter bit PESSIMISTIC_MODE     = 1'b0
) (
  input logic         clock,
  input logic         reset_n,
  blk_359621_if.slave bus
);
  localparam int NC = NUM_INPUT_CHANNELS;
  localparam int CW = $clog2(CHANNEL_BUFFER_DEPTH + 1);
  localparam int PW = $clog2(MAX_IN_FLIGHT + 1);
  localparam int MW = (CW > PW) ? CW : PW;
  localparam logic [PW-1:0] PMAX = PW'(MAX_IN_FLIGHT);

  logic [PW-1:0] pending      [NC];
  logic [PW-1:0] pending_next [NC];
  logic [NC-1:0] issue;
  logic [NC-1:0] overflow;
  logic [NC-1:0] underflow;
  logic          error_q;

  assign issue = bus.trigger_icd & {NC{bus.trigger_valid}};

  // Issue and commit in the same cycle cancel; otherwise step by one and saturate at the ends.
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      pending_next[i] = pending[i];
      overflow[i]     = 1'b0;
      underflow[i]    = 1'b0;
      if (issue[i] && !bus.decode_dequeue[i]) begin
        if (pending[i] == PMAX) overflow[i] = 1'b1;
        else                    pending_next[i] = pending[i] + 1'b1;
      end else if (!issue[i] && bus.decode_dequeue[i]) begin
        if (pending[i] == '0) underflow[i] = 1'b1;
        else                  pending_next[i] = pending[i] - 1'b1;
      end
    end
  end

  // A flush discards the uncommitted instructions and their dequeues, but keeps the sticky error.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) pending[i] <= '0;
      error_q <= 1'b0;
    end else if (bus.pipeline_flush) begin
      for (int i = 0; i < NC; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NC; i++) pending[i] <= pending_next[i];
      if (|(overflow | underflow)) error_q <= 1'b1;
    end
  end

  assign bus.error = error_q;

  for (genvar g = 0; g < NC; g++) begin : g_ch
    logic [MW-1:0] count_ext;
    logic [MW-1:0] pending_ext;
    logic          reserved_all;

    assign count_ext   = MW'(bus.input_channel_counts[g*CW +: CW]);
    assign pending_ext = MW'(pending[g]);
    // Empty to the trigger stage once every buffered item is already claimed by an in-flight dequeue.
    assign reserved_all = PESSIMISTIC_MODE ? (pending[g] != '0) : (count_ext <= pending_ext);
    assign bus.updated_input_channel_empty_status[g] = bus.input_channel_empty_status[g] | reserved_all;
    assign bus.pending_dequeue_counts[g*PW +: PW]     = pending[g];
  end
endmodule

// File: tb/tb_blk_359621.sv
// tb/tb_blk_359621.sv - directed and model-checked bench for blk_359621 in both modes
module tb_blk_359621;
  localparam int NC = 4;
  localparam int CW = 3;
  localparam int PW = 2;

  logic clock = 1'b0;
  logic reset_n;
  logic [NC-1:0]    empty;
  logic [NC*CW-1:0] counts;
  logic             tv;
  logic [NC-1:0]    icd;
  logic [NC-1:0]    dd;
  logic             flush;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  blk_359621_if #(.NC(NC), .CW(CW), .PW(PW)) ifc_c ();
  blk_359621_if #(.NC(NC), .CW(CW), .PW(PW)) ifc_p ();

  assign ifc_c.input_channel_empty_status = empty;
  assign ifc_c.input_channel_counts       = counts;
  assign ifc_c.trigger_valid              = tv;
  assign ifc_c.trigger_icd                = icd;
  assign ifc_c.decode_dequeue             = dd;
  assign ifc_c.pipeline_flush             = flush;
  assign ifc_p.input_channel_empty_status = empty;
  assign ifc_p.input_channel_counts       = counts;
  assign ifc_p.trigger_valid              = tv;
  assign ifc_p.trigger_icd                = icd;
  assign ifc_p.decode_dequeue             = dd;
  assign ifc_p.pipeline_flush             = flush;

  blk_359621 #(.NUM_INPUT_CHANNELS(4), .CHANNEL_BUFFER_DEPTH(4), .MAX_IN_FLIGHT(3),
               .PESSIMISTIC_MODE(1'b0)) dut_c (.clock(clock), .reset_n(reset_n), .bus(ifc_c));
  blk_359621 #(.NUM_INPUT_CHANNELS(4), .CHANNEL_BUFFER_DEPTH(4), .MAX_IN_FLIGHT(3),
               .PESSIMISTIC_MODE(1'b1)) dut_p (.clock(clock), .reset_n(reset_n), .bus(ifc_p));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*CW-1:0] pack_counts(input int c0, input int c1, input int c2, input int c3);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  int mp [NC];
  logic [NC-1:0] iss;
  logic [NC-1:0] exp_c;
  logic [NC-1:0] exp_p;
  logic [NC*PW-1:0] exp_pend;
  int cnt [NC];

  initial begin
    reset_n = 1'b0; empty = '0; counts = pack_counts(2, 2, 2, 2);
    tv = 1'b0; icd = '0; dd = '0; flush = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("t1_upd_c", 32'(ifc_c.updated_input_channel_empty_status), 32'h0);
    chk("t1_upd_p", 32'(ifc_p.updated_input_channel_empty_status), 32'h0);
    chk("t1_pend",  32'(ifc_c.pending_dequeue_counts), 32'h0);
    chk("t1_err",   32'(ifc_c.error), 32'h0);

    // counting: two issues on ch0 with count 2
    tv = 1'b1; icd = 4'b0001;
    chk("t2_same_cycle", 32'(ifc_c.updated_input_channel_empty_status), 32'h0);
    tick();
    chk("t2_pend1",  32'(ifc_c.pending_dequeue_counts), 32'h1);
    chk("t2_upd_c1", 32'(ifc_c.updated_input_channel_empty_status), 32'h0);
    chk("t2_upd_p1", 32'(ifc_p.updated_input_channel_empty_status), 32'h1);
    tick();
    chk("t2_pend2",  32'(ifc_c.pending_dequeue_counts), 32'h2);
    chk("t2_upd_c2", 32'(ifc_c.updated_input_channel_empty_status), 32'h1);
    tv = 1'b0; icd = '0; dd = 4'b0001;
    tick(); tick();
    dd = '0;
    chk("t2_drain", 32'(ifc_c.pending_dequeue_counts), 32'h0);

    // pessimistic: ch1 with count 3
    counts = pack_counts(2, 3, 2, 2);
    tv = 1'b1; icd = 4'b0010;
    tick();
    tv = 1'b0; icd = '0;
    chk("t3_upd_p", 32'(ifc_p.updated_input_channel_empty_status), 32'h2);
    chk("t3_upd_c", 32'(ifc_c.updated_input_channel_empty_status), 32'h0);
    chk("t3_pend",  32'(ifc_p.pending_dequeue_counts), 32'h4);
    tick();
    dd = 4'b0010;
    tick();
    dd = '0;
    chk("t3_pend0", 32'(ifc_p.pending_dequeue_counts), 32'h0);
    chk("t3_upd_p0", 32'(ifc_p.updated_input_channel_empty_status), 32'h0);

    // issue and commit same cycle on ch2
    tv = 1'b1; icd = 4'b0100;
    tick();
    dd = 4'b0100;
    tick();
    tv = 1'b0; icd = '0; dd = '0;
    chk("t4_pend", 32'(ifc_c.pending_dequeue_counts), 32'h10);
    chk("t4_err",  32'(ifc_c.error), 32'h0);

    // flush with pending {1,2,0,1}
    dd = 4'b0100;
    tick();
    dd = '0; tv = 1'b1; icd = 4'b1011;
    tick();
    icd = 4'b0010;
    tick();
    chk("t5_pend_pre", 32'(ifc_c.pending_dequeue_counts), 32'h49);
    empty = 4'b0101; flush = 1'b1; icd = 4'b1000;
    tick();
    chk("t5_pend_c", 32'(ifc_c.pending_dequeue_counts), 32'h0);
    chk("t5_pend_p", 32'(ifc_p.pending_dequeue_counts), 32'h0);
    chk("t5_upd_c",  32'(ifc_c.updated_input_channel_empty_status), 32'h5);
    chk("t5_upd_p",  32'(ifc_p.updated_input_channel_empty_status), 32'h5);
    flush = 1'b0; empty = '0; tv = 1'b0; icd = '0;
    chk("t5_err", 32'(ifc_c.error), 32'h0);

    // underflow, sticky through flush, cleared by reset
    dd = 4'b0001;
    tick();
    dd = '0;
    chk("t6_err",  32'(ifc_c.error), 32'h1);
    chk("t6_pend", 32'(ifc_c.pending_dequeue_counts), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_err_flush", 32'(ifc_p.error), 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_err_rst", 32'(ifc_c.error), 32'h0);

    // overflow at MAX_IN_FLIGHT
    tv = 1'b1; icd = 4'b0001;
    tick(); tick(); tick();
    chk("t7_pend3", 32'(ifc_c.pending_dequeue_counts), 32'h3);
    chk("t7_err0",  32'(ifc_c.error), 32'h0);
    tick();
    tv = 1'b0; icd = '0;
    chk("t7_pend_sat", 32'(ifc_c.pending_dequeue_counts), 32'h3);
    chk("t7_err1",     32'(ifc_c.error), 32'h1);
    chk("t7_upd_c",    32'(ifc_c.updated_input_channel_empty_status), 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // legal random traffic against a reference model
    for (int i = 0; i < NC; i++) mp[i] = 0;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < NC; i++) cnt[i] = int'($urandom_range(0, 4));
      counts = pack_counts(cnt[0], cnt[1], cnt[2], cnt[3]);
      for (int i = 0; i < NC; i++) empty[i] = (cnt[i] == 0);
      tv    = 1'($urandom);
      icd   = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      iss   = tv ? icd : '0;
      for (int i = 0; i < NC; i++) begin
        dd[i] = (mp[i] > 0) ? 1'($urandom) : 1'b0;
        if (mp[i] == 3 && iss[i] && !dd[i]) dd[i] = 1'b1;
        exp_c[i] = empty[i] | (cnt[i] <= mp[i]);
        exp_p[i] = empty[i] | (mp[i] != 0);
      end
      #1;
      chk("r_upd_c", 32'(ifc_c.updated_input_channel_empty_status), 32'(exp_c));
      chk("r_upd_p", 32'(ifc_p.updated_input_channel_empty_status), 32'(exp_p));
      tick();
      for (int i = 0; i < NC; i++) begin
        if (flush) mp[i] = 0;
        else       mp[i] = mp[i] + int'(iss[i]) - int'(dd[i]);
        exp_pend[i*PW +: PW] = 2'(mp[i]);
      end
      chk("r_pend", 32'(ifc_c.pending_dequeue_counts), 32'(exp_pend));
      chk("r_err",  32'(ifc_c.error | ifc_p.error), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
